// File: rtl/port_requester.sv
// port_requester: per-port ingress requester in front of the shared port_arbitrator.
//
// Buffers ingress words in a local FIFO that holds {eop, sop, data} per entry. When a
// complete packet is stored it raises o_req. After the one-cycle grant on i_resp, it
// streams the head packet, one word per cycle with no backpressure, framed by the
// stored sop/eop flags.
//
// Optional feature (macro PORT_REQ_TIMEOUT_EN): while requesting, a counter limits the
// grant wait to TIMEOUT cycles. On expiry o_timeout pulses and the head packet is
// drained silently (DROP state). Without the macro, REQ waits indefinitely and
// o_timeout is tied low.
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_wr_en/sop/eop/data      ingress word and framing flags
//   o_full, o_ovf             FIFO full flag, write-while-full pulse
//   o_req, i_resp             request to / grant pulse from the arbiter
//   o_vld/sop/eop/data        egress word stream toward the cache write path
//   o_timeout                 grant-timeout drop pulse
module port_requester #(
  parameter int unsigned DW      = 32,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic          i_wr_sop,
  input  logic          i_wr_eop,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_full,
  output logic          o_ovf,
  output logic          o_req,
  input  logic          i_resp,
  output logic          o_vld,
  output logic          o_sop,
  output logic          o_eop,
  output logic [DW-1:0] o_data,
  output logic          o_timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("port_requester: DEPTH must be a power of 2 and at least 4");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("port_requester: TIMEOUT must be at least 2");
  end

`ifdef PORT_REQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {StIdle, StReq, StSend, StDrop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StReq, StSend} state_e;
`endif

  // FIFO storage and pointers
  logic [DW+1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;

  state_e        state_q, state_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          req_q, req_d;
  logic          vld_q, vld_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic [DW-1:0] data_q, data_d;

`ifdef PORT_REQ_TIMEOUT_EN
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_q, timeout_d;
`endif

  logic          wr_accept;
  logic          rd_en;
  logic [DW+1:0] rd_word;
  logic          pkt_inc;
  logic          pkt_dec;

  // full_q mirrors count_q == DEPTH, so it can gate writes directly.
  assign wr_accept = i_wr_en & ~full_q;
  assign rd_word   = mem_q[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= {i_wr_eop, i_wr_sop, i_wr_data};
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    vld_d   = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    data_d  = data_q;
    rd_en   = 1'b0;
`ifdef PORT_REQ_TIMEOUT_EN
    tmo_d     = tmo_q;
    timeout_d = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        if (pkt_cnt_q != '0) begin
          state_d = StReq;
          req_d   = 1'b1;
`ifdef PORT_REQ_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      StReq: begin
        if (i_resp) begin
          state_d = StSend;
        end else begin
          req_d = 1'b1;
`ifdef PORT_REQ_TIMEOUT_EN
          if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d   = StDrop;
            req_d     = 1'b0;
            timeout_d = 1'b1;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
`endif
        end
      end
      StSend: begin
        // A full packet is stored, so count_q only guards against misuse upstream.
        if (count_q != '0) begin
          rd_en  = 1'b1;
          vld_d  = 1'b1;
          sop_d  = rd_word[DW];
          eop_d  = rd_word[DW+1];
          data_d = rd_word[DW-1:0];
          // Leaving now means IDLE coincides with o_eop, so o_req rises a cycle later.
          if (rd_word[DW+1]) begin
            state_d = StIdle;
          end
        end
      end
`ifdef PORT_REQ_TIMEOUT_EN
      StDrop: begin
        if (count_q != '0) begin
          rd_en = 1'b1;
          if (rd_word[DW+1]) begin
            state_d = StIdle;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    pkt_inc  = wr_accept & i_wr_eop;
    pkt_dec  = rd_en & rd_word[DW+1];
    wr_ptr_d = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_accept) - CW'(rd_en);
    full_d   = (count_d == CW'(DEPTH));
    ovf_d    = i_wr_en & full_q;

    case ({pkt_inc, pkt_dec})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pkt_cnt_q <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      req_q     <= 1'b0;
      vld_q     <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      data_q    <= '0;
`ifdef PORT_REQ_TIMEOUT_EN
      tmo_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pkt_cnt_q <= pkt_cnt_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      req_q     <= req_d;
      vld_q     <= vld_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      data_q    <= data_d;
`ifdef PORT_REQ_TIMEOUT_EN
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign o_full = full_q;
  assign o_ovf  = ovf_q;
  assign o_req  = req_q;
  assign o_vld  = vld_q;
  assign o_sop  = sop_q;
  assign o_eop  = eop_q;
  assign o_data = data_q;
`ifdef PORT_REQ_TIMEOUT_EN
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_port_requester.sv
module tb_port_requester;

  localparam int unsigned DW      = 32;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned TIMEOUT = 16;

  logic          i_clk;
  logic          i_rst;
  logic          i_wr_en;
  logic          i_wr_sop;
  logic          i_wr_eop;
  logic [DW-1:0] i_wr_data;
  logic          o_full;
  logic          o_ovf;
  logic          o_req;
  logic          i_resp;
  logic          o_vld;
  logic          o_sop;
  logic          o_eop;
  logic [DW-1:0] o_data;
  logic          o_timeout;

  port_requester #(
    .DW     (DW),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) u_dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr_en  (i_wr_en),
    .i_wr_sop (i_wr_sop),
    .i_wr_eop (i_wr_eop),
    .i_wr_data(i_wr_data),
    .o_full   (o_full),
    .o_ovf    (o_ovf),
    .o_req    (o_req),
    .i_resp   (i_resp),
    .o_vld    (o_vld),
    .o_sop    (o_sop),
    .o_eop    (o_eop),
    .o_data   (o_data),
    .o_timeout(o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic          en;
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           wq[$];
  logic [DW+1:0] cap[$];    // {sop, eop, data} of every o_vld word
  int            req_rise[$];
  int            eop_cyc[$];
  int            checks;
  int            errors;
  int            cyc;
  int            vld_first;
  int            vld_last;
  int            ovf_seen;
  int            tmo_seen;
  int            req_hi_cyc;
  logic          req_prev;
  int            start;
  int            bad;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic s, input logic e);
    wr_t w;
    w.en   = 1'b1;
    w.sop  = s;
    w.eop  = e;
    w.data = d;
    wq.push_back(w);
  endtask

  task automatic push_idle();
    wr_t w;
    w = '0;
    wq.push_back(w);
  endtask

  task automatic clear_obs();
    cap.delete();
    req_rise.delete();
    eop_cyc.delete();
    vld_first  = -1;
    vld_last   = -1;
    ovf_seen   = 0;
    tmo_seen   = 0;
    req_hi_cyc = 0;
    req_prev   = o_req;
  endtask

  // Runs n cycles: feeds the write queue, optionally grants whenever o_req is seen,
  // and records what the DUT drives after each edge.
  task automatic run(input int n, input bit grant);
    wr_t w;
    for (int c = 0; c < n; c++) begin
      if (wq.size() > 0) begin
        w = wq.pop_front();
      end else begin
        w = '0;
      end
      i_wr_en   = w.en;
      i_wr_sop  = w.sop;
      i_wr_eop  = w.eop;
      i_wr_data = w.data;
      i_resp    = grant & o_req;
      tick();
      cyc++;
      if (o_vld) begin
        cap.push_back({o_sop, o_eop, o_data});
        if (vld_first < 0) vld_first = cyc;
        vld_last = cyc;
        if (o_eop) eop_cyc.push_back(cyc);
      end
      if (o_req && !req_prev) req_rise.push_back(cyc);
      req_prev = o_req;
      if (o_req) req_hi_cyc++;
      if (o_ovf) ovf_seen++;
      if (o_timeout) tmo_seen++;
    end
    i_wr_en   = 1'b0;
    i_wr_sop  = 1'b0;
    i_wr_eop  = 1'b0;
    i_wr_data = '0;
    i_resp    = 1'b0;
  endtask

  task automatic check_outs_zero(input string tag);
    check_eq(tag, {o_req, o_vld, o_sop, o_eop, o_full, o_ovf, o_timeout, o_data}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    i_rst     = 1'b1;
    i_wr_en   = 1'b0;
    i_wr_sop  = 1'b0;
    i_wr_eop  = 1'b0;
    i_wr_data = '0;
    i_resp    = 1'b0;
    tick();
    tick();
    check_outs_zero("reset_outs");
    i_rst = 1'b0;
    tick();
    clear_obs();

    // 1: single 4-word packet, grant three cycles into the request
    for (int i = 0; i < 4; i++) push_word(DW'(32'hA0 + i), i == 0, i == 3);
    run(4, 1'b0);
    run(1, 1'b0);
    check_eq("t1_req_latency", o_req, 1'b1);
    run(2, 1'b0);
    check_eq("t1_req_hold", o_req, 1'b1);
    i_resp = 1'b1;
    tick();
    cyc++;
    i_resp = 1'b0;
    check_eq("t1_req_drop", o_req, 1'b0);
    check_eq("t1_no_vld_yet", o_vld, 1'b0);
    clear_obs();
    start = cyc;
    run(6, 1'b0);
    check_eq("t1_words", cap.size(), 4);
    for (int i = 0; i < 4; i++) begin
      logic [DW+1:0] exp;
      exp = {i == 0, i == 3, DW'(32'hA0 + i)};
      if (i < cap.size()) check_eq($sformatf("t1_word%0d", i), cap[i], exp);
    end
    check_eq("t1_first_vld", vld_first, start + 1);
    check_eq("t1_burst_len", vld_last - vld_first + 1, 4);
    check_eq("t1_idle_req", o_req, 1'b0);

    // 2: back-to-back 2-word packets with immediate grants
    clear_obs();
    push_word(32'hB0, 1'b1, 1'b0);
    push_word(32'hB1, 1'b0, 1'b1);
    push_word(32'hC0, 1'b1, 1'b0);
    push_word(32'hC1, 1'b0, 1'b1);
    run(16, 1'b1);
    check_eq("t2_words", cap.size(), 4);
    if (cap.size() == 4) begin
      check_eq("t2_b0", cap[0], {2'b10, 32'hB0});
      check_eq("t2_b1", cap[1], {2'b01, 32'hB1});
      check_eq("t2_c0", cap[2], {2'b10, 32'hC0});
      check_eq("t2_c1", cap[3], {2'b01, 32'hC1});
    end
    check_eq("t2_req_rises", req_rise.size(), 2);
    if (req_rise.size() == 2 && eop_cyc.size() >= 1)
      check_eq("t2_req_after_eop", req_rise[1], eop_cyc[0] + 1);

    // 3: DEPTH+1 writes without a grant; last stored word closes a max-length packet
    clear_obs();
    for (int i = 0; i < DEPTH; i++) push_word(DW'(32'h100 + i), i == 0, i == DEPTH - 1);
    push_word(32'hDEAD, 1'b1, 1'b1);
    run(DEPTH - 1, 1'b0);
    check_eq("t3_not_full", o_full, 1'b0);
    run(1, 1'b0);
    check_eq("t3_full", o_full, 1'b1);
    check_eq("t3_no_ovf_yet", o_ovf, 1'b0);
    run(1, 1'b0);
    check_eq("t3_ovf_pulse", o_ovf, 1'b1);
    run(1, 1'b0);
    check_eq("t3_ovf_clear", o_ovf, 1'b0);
    check_eq("t3_ovf_count", ovf_seen, 1);
    check_eq("t3_still_full", o_full, 1'b1);
    clear_obs();
    run(DEPTH + 8, 1'b1);
    check_eq("t3_words", cap.size(), DEPTH);
    bad = 0;
    for (int i = 0; i < cap.size(); i++) begin
      logic [DW+1:0] exp;
      exp = {i == 0, i == DEPTH - 1, DW'(32'h100 + i)};
      if (cap[i] !== exp) bad++;
    end
    check_eq("t3_content_bad", bad, 0);
    check_eq("t3_full_after", o_full, 1'b0);
    check_eq("t3_no_extra_req", req_rise.size(), 0);

    // 4: eop written in the same cycle the stored eop is read
    clear_obs();
    start = cyc;
    push_word(32'hD0, 1'b1, 1'b0);
    push_word(32'hD1, 1'b0, 1'b1);
    push_idle();
    push_idle();
    push_idle();
    push_word(32'hE0, 1'b1, 1'b1);
    run(16, 1'b1);
    check_eq("t4_words", cap.size(), 3);
    if (cap.size() == 3) begin
      check_eq("t4_d0", cap[0], {2'b10, 32'hD0});
      check_eq("t4_d1", cap[1], {2'b01, 32'hD1});
      check_eq("t4_e0", cap[2], {2'b11, 32'hE0});
    end
    if (eop_cyc.size() >= 1) check_eq("t4_coincide", eop_cyc[0], start + 6);
    check_eq("t4_req_rises", req_rise.size(), 2);

    // 5: reset during word 2 of a 5-word packet
    clear_obs();
    for (int i = 0; i < 5; i++) push_word(DW'(32'hF0 + i), i == 0, i == 4);
    run(9, 1'b1);
    check_eq("t5_words_before", cap.size(), 2);
    if (cap.size() == 2) check_eq("t5_word2", cap[1], {2'b00, 32'hF1});
    i_rst = 1'b1;
    #1;
    check_outs_zero("t5_async_rst");
    tick();
    check_outs_zero("t5_rst_next");
    i_rst = 1'b0;
    clear_obs();
    run(8, 1'b1);
    check_eq("t5_no_req", req_rise.size(), 0);
    check_eq("t5_no_words", cap.size(), 0);
    check_eq("t5_no_eop", eop_cyc.size(), 0);
    push_word(32'h60, 1'b1, 1'b1);
    run(8, 1'b1);
    check_eq("t5_new_words", cap.size(), 1);
    if (cap.size() == 1) check_eq("t5_new_word", cap[0], {2'b11, 32'h60});

`ifdef PORT_REQ_TIMEOUT_EN
    // 6: withheld grant times out and the packet is dropped silently
    clear_obs();
    push_word(32'h1234, 1'b1, 1'b1);
    run(30, 1'b0);
    check_eq("t6_req_cycles", req_hi_cyc, TIMEOUT);
    check_eq("t6_timeout_pulses", tmo_seen, 1);
    check_eq("t6_no_vld", cap.size(), 0);
    check_eq("t6_req_low", o_req, 1'b0);
    clear_obs();
    push_word(32'h5678, 1'b1, 1'b1);
    run(10, 1'b1);
    check_eq("t6_next_words", cap.size(), 1);
    if (cap.size() == 1) check_eq("t6_next_word", cap[0], {2'b11, 32'h5678});
    check_eq("t6_next_no_tmo", tmo_seen, 0);
`else
    // Without the timeout feature a withheld grant keeps the request up indefinitely
    clear_obs();
    push_word(32'h1234, 1'b1, 1'b1);
    run(40, 1'b0);
    check_eq("t6_req_waits", o_req, 1'b1);
    check_eq("t6_no_timeout", tmo_seen, 0);
    check_eq("t6_no_vld", cap.size(), 0);
    clear_obs();
    run(6, 1'b1);
    check_eq("t6_words", cap.size(), 1);
    if (cap.size() == 1) check_eq("t6_word", cap[0], {2'b11, 32'h1234});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_requester.md
# port_requester

Per-port ingress requester that sits between one input port and the shared `port_arbitrator`. It buffers incoming packets in a local FIFO and raises a request once a complete packet is stored. After the one-cycle grant pulse it streams that packet to the cache write path, framed with sop/eop; the eop closes the arbiter's working window. One instance is built per port (PORTNUM instances total).

## Interface
- `DW`, 32, data word width
- `DEPTH`, 64, FIFO depth in words; power of 2, ≥4; maximum packet length is DEPTH words
- `TIMEOUT`, 1024, grant-wait limit in cycles (used only with `PORT_REQ_TIMEOUT_EN`)
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset; asynchronous, active-high
- `i_wr_en`  in  1  ingress word valid
- `i_wr_sop`  in  1  first word of packet (qualified by `i_wr_en`)
- `i_wr_eop`  in  1  last word of packet (qualified by `i_wr_en`)
- `i_wr_data`  in  DW  ingress word
- `o_full`  out  1  FIFO holds DEPTH words
- `o_ovf`  out  1  one-cycle pulse: write attempted while full
- `o_req`  out  1  request to arbiter (one bit of its `i_req`)
- `i_resp`  in  1  grant pulse from arbiter (one bit of its `o_resp`)
- `o_vld`  out  1  output word valid
- `o_sop`  out  1  first output word
- `o_eop`  out  1  last output word (drives arbiter `i_eop` via the port mux)
- `o_data`  out  DW  output word
- `o_timeout`  out  1  one-cycle pulse: packet dropped after grant timeout (tied 0 without the macro)

## Operation
- FIFO stores {eop, sop, data} per word. Word count range is 0..DEPTH.
- A write when `o_full`=1 is discarded and `o_ovf` pulses. The upstream source must honour `o_full`.
- `pkt_cnt`:
  - +1 on an accepted write with eop.
  - −1 on a FIFO read of an eop word.
  - Both events in the same cycle leave it unchanged.
- FSM states: IDLE, REQ, SEND, DROP (DROP exists only with the macro).
  - IDLE → REQ when `pkt_cnt`≠0.
  - REQ: `o_req`=1. On `i_resp`=1, go to SEND.
  - SEND: `o_req`=0 and one FIFO read per cycle, with no backpressure. Reads stop after the eop word is read. Return to IDLE in the cycle `o_eop`=1 is driven.
  - DROP: read words with `o_vld`=0 until the eop word is read, then go to IDLE.
- `o_sop`, `o_eop` and `o_data` are meaningful only when `o_vld`=1. They are taken from the stored flags, not regenerated.
- An `i_resp` received outside REQ is ignored.
- A reset in any state empties the FIFO, clears `pkt_cnt` and sets the FSM to IDLE. A packet in flight is truncated with no `o_eop`.

## Timing
- All outputs are registered. Reset values: `o_req`=0, `o_vld`=0, `o_sop`=0, `o_eop`=0, `o_data`=0, `o_full`=0, `o_ovf`=0, `o_timeout`=0.
- Request latency: an eop word written at edge t raises `o_req` no later than cycle t+2.
- Grant: `i_resp` sampled high at edge t, so `o_req` is low from t+1. The first FIFO read is at t+1 and the first `o_vld`/`o_sop` at t+2.
- Burst: an N-word packet gives `o_vld`=1 for exactly N consecutive cycles.
- `o_req` must not re-assert before the cycle after `o_eop`. This guarantees the arbiter has cleared its working state.
- `o_full` and `o_ovf` update the cycle after the causing write.

## Configuration
- `PORT_REQ_TIMEOUT_EN` defined:
  - A counter runs in REQ and clears on entry to REQ.
  - If it reaches TIMEOUT with no `i_resp`, `o_timeout` pulses one cycle and the FSM enters DROP. The head packet is discarded.
- Not defined: no counter and no DROP state. REQ waits indefinitely and `o_timeout`=0.

## Test plan
- Reset, then write a 4-word packet (0xA0..0xA3), grant 3 cycles after `o_req`: `o_req` drops the cycle after `i_resp`. `o_vld` is high for 4 cycles with data 0xA0..0xA3, `o_sop` on 0xA0 and `o_eop` on 0xA3. Ends in IDLE.
- Two back-to-back 2-word packets with immediate grants: the second `o_req` rises the cycle after the first `o_eop`. Both packets are emitted intact and in order.
- Write DEPTH+1 words without a grant: `o_full`=1 after 64 words, one `o_ovf` pulse, and the stored contents are unchanged.
- Write an eop word in the same cycle a stored eop word is read: `pkt_cnt` is unchanged and the following packet is still requested.
- Assert `i_rst` mid-SEND (word 2 of 5): all outputs are 0 the next cycle, the FIFO is empty, `o_req` stays 0 and no `o_eop` is seen.
- With `PORT_REQ_TIMEOUT_EN` and TIMEOUT=16, withhold the grant: `o_timeout` pulses after 16 REQ cycles and the packet is dropped with no `o_vld`. The next packet is requested normally.
